clk_period_meter: RTL
=====================

# clk_period_meter

Measures the period and high time of an asynchronous clock-like input `sigin` in units of `clkin` cycles, optionally averaged over 1, 2, 4 or 8 consecutive periods. It is the measuring counterpart of the clock divider. It sits on the receiving side of a divided clock, for example to recover a divisor or to check a divider output on the bench. Results are reported through a start/busy/valid handshake, and a timeout flags a stalled input.

## Interface
- `CNT_W`, 16: width of the period counter and of the `period`/`high_time` outputs.
- `SYNC_STAGES`, 2: flip-flop stages in the `sigin` synchronizer (minimum 2).
- `clkin`  in  1  system clock; all logic is on `posedge clkin`.
- `reset`  in  1  synchronous, active-low.
- `start`  in  1  request a measurement; sampled only in IDLE.
- `avg_log2`  in  2  number of periods averaged is N = 2^avg_log2; sampled with `start`.
- `sigin`  in  1  asynchronous input being measured.
- `period`  out  CNT_W  averaged period in `clkin` cycles.
- `high_time`  out  CNT_W  high-level cycles within the last measured period.
- `busy`  out  1  a measurement is in progress.
- `valid`  out  1  one-cycle pulse when `period`/`high_time` update.
- `timeout`  out  1  the last measurement aborted because no edge arrived; sticky until the next accepted `start`.

## Operation
- Reset: when `reset`=0 at a clock edge, the block goes to IDLE and all outputs, counters, the accumulator and synchronizer flops clear to 0.
- Synchronizer: `sigin` passes through SYNC_STAGES flops to give `s`, plus one more flop `s_d`. Rising edge `rise = s & ~s_d`.
- States:
  - IDLE → ARM on `start`=1. On that transition:
    - latch `avg_log2`;
    - clear `cnt`, `acc`, `nper` and `timeout`;
    - set `busy`.
  - `start` in any other state is ignored.
  - ARM: `cnt` increments each cycle.
    - On `rise`, go to MEAS with `cnt`←1 and `hcnt`←1.
  - MEAS: `cnt` increments each cycle; `hcnt` increments in cycles where `s`=1.
    - On `rise`:
      - `acc += cnt`, `nper += 1`, `last_h ← hcnt`;
      - reload `cnt`←1 and `hcnt`←1.
      - If `nper` reaches N, go to DONE.
  - DONE (one cycle):
    - `period ← acc >> avg_log2` (lower CNT_W bits);
    - `high_time ← last_h`;
    - `valid`=1, `busy`=0; go to IDLE.
- Arithmetic: `acc` is CNT_W+3 bits and cannot overflow because each term is at most 2^CNT_W−1. Averaging truncates and does not round.
- Timeout: in ARM or MEAS, if `cnt` = all-ones and `rise`=0 in that cycle:
  - `timeout`←1, `busy`←0, go to IDLE;
  - no `valid` pulse; `period` and `high_time` keep their previous values.
- Simultaneous events:
  - A `rise` in the same cycle as `cnt` = all-ones counts as an edge, not a timeout.
  - `start` in the DONE cycle is ignored.
  - `start` in the first IDLE cycle after DONE or timeout is accepted.
- Reset mid-measurement aborts immediately. No `valid` is issued, and `period`/`high_time` read 0 afterwards.

## Timing
- `start` high at edge k (in IDLE) gives `busy`=1 from k+1.
- `sigin` edge detection latency is SYNC_STAGES+1 cycles. This is a constant offset, so it cancels out of `period`.
- An ideal periodic `sigin` of P `clkin` cycles (P ≥ 2) measures exactly P. Asynchronous jitter gives ±1 cycle per edge.
- The final `rise` is at edge m, DONE is at m+1, and `valid`/`busy`=0/new outputs are visible after edge m+1.
- Total latency after `start` is about (N+1)·P + SYNC_STAGES + 3 cycles.
- The timeout fires 2^CNT_W−1 cycles after the last `rise`, or after entering ARM.
- `valid` is exactly one cycle wide. `period`/`high_time` are stable between `valid` pulses.

## Test plan
- `sigin` = `clkin`/10 (5 high, 5 low), `avg_log2`=0, `start` pulse → one `valid`; `period`=10, `high_time`=5, `busy` low the same cycle as `valid`.
- `sigin` with 3 high/4 low, `avg_log2`=0 → `period`=7, `high_time`=3; repeated `start` gives identical results.
- Periods 10,10,12,12 (high 5,5,6,6), `avg_log2`=2 → `period`=11, `high_time`=6.
- CNT_W=8, `sigin` held 0 after `start` → `timeout`=1 and `busy`=0 exactly 255 cycles after entering ARM; no `valid`; `period` unchanged. A following `start` clears `timeout`.
- `start` pulsed again while `busy`, and in the DONE cycle → ignored; only one `valid`; `avg_log2` changes while `busy` have no effect.
- `reset`=0 mid-MEAS → at the next edge all outputs are 0 and the state is IDLE; a new `start` with `sigin`=`clkin`/4 gives `period`=4.

Source files
------------

// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous input in clkin cycles,
// averaged over 1/2/4/8 periods, with start/busy/valid handshake and timeout.
module clk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       avg_log2,
    input  logic             sigin,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             busy,
    output logic             valid,
    output logic             timeout
);

    typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s, s_d, rise;
    logic [CNT_W-1:0]       cnt, hcnt, last_h;
    logic [CNT_W+2:0]       acc, acc_sh;
    logic [3:0]             nper, n_target;
    logic [1:0]             avg;
    logic                   cnt_max;

    assign s        = sync[SYNC_STAGES-1];
    assign rise     = s & ~s_d;
    assign cnt_max  = &cnt;
    assign n_target = 4'd1 << avg;
    assign acc_sh   = acc >> avg;

    always_ff @(posedge clkin) begin
        if (!reset) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sigin};
            s_d  <= s;
        end
    end

    always_ff @(posedge clkin) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            last_h    <= '0;
            acc       <= '0;
            nper      <= '0;
            avg       <= '0;
            period    <= '0;
            high_time <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ARM;
                        avg     <= avg_log2;
                        cnt     <= '0;
                        acc     <= '0;
                        nper    <= '0;
                        timeout <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ARM: begin
                    if (rise) begin
                        state <= MEAS;
                        cnt   <= CNT_W'(1);
                        hcnt  <= CNT_W'(1);
                    end else if (cnt_max) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MEAS: begin
                    // An edge coinciding with a full counter still counts as a period.
                    if (rise) begin
                        acc    <= acc + {3'b000, cnt};
                        nper   <= nper + 4'd1;
                        last_h <= hcnt;
                        cnt    <= CNT_W'(1);
                        hcnt   <= CNT_W'(1);
                        if (nper + 4'd1 == n_target) state <= DONE;
                    end else if (cnt_max) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        hcnt <= hcnt + {{(CNT_W-1){1'b0}}, s};
                    end
                end
                DONE: begin
                    period    <= acc_sh[CNT_W-1:0];
                    high_time <= last_h;
                    valid     <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
